// File: rtl/tic_tac_pkg.sv
// ---------------------------------------------------------------------------
// tic_tac_pkg : shared types and button indices for the game controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tic_tac_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_ARM    = 2'd1,
    BTN_HELD   = 2'd2,
    BTN_DISARM = 2'd3
  } btn_state_t;

  localparam int BTN_START  = 0;
  localparam int BTN_MOVE   = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_SHOW   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if : raw button pins in, press pulses and levels out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] level;

  modport master (output btn_n, input press, input level);
  modport slave  (input btn_n, output press, output level);
endinterface

`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel : 2-FF synchronizer + debounce FSM for one button.
// Optional auto-repeat when AUTO_REPEAT_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_channel
  import tic_tac_pkg::*;
#(
  parameter int DB_CYCLES     = 500000
`ifdef AUTO_REPEAT_EN
  ,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_level
);

`ifdef AUTO_REPEAT_EN
  localparam int c_cnt_w = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
`else
  localparam int c_cnt_w = $clog2(max3(DB_CYCLES, 1, 1) + 1);
`endif
  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DB_CYCLES - 1);

  logic               r_ff1;
  logic               r_ff2;
  logic               w_sync_p;
  btn_state_t         r_state;
  btn_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_press;
  logic               w_press_nxt;
  logic               w_cnt_last;
  logic               w_rpt_hit;

  // Synchronizer resets to "released" so a held button is seen as a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
    end else begin
      r_ff1 <= i_btn_n;
      r_ff2 <= r_ff1;
    end
  end

  assign w_sync_p   = ~r_ff2;
  assign w_cnt_last = (r_cnt == c_db_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BTN_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_press <= w_press_nxt;
      if (r_state != w_state_nxt)
        r_cnt <= '0;
      else if (r_state == BTN_ARM || r_state == BTN_DISARM)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BTN_IDLE:   if (w_sync_p)        w_state_nxt = BTN_ARM;
      BTN_ARM:    if (!w_sync_p)       w_state_nxt = BTN_IDLE;
                  else if (w_cnt_last) w_state_nxt = BTN_HELD;
      BTN_HELD:   if (!w_sync_p)       w_state_nxt = BTN_DISARM;
      BTN_DISARM: if (w_sync_p)        w_state_nxt = BTN_HELD;
                  else if (w_cnt_last) w_state_nxt = BTN_IDLE;
      default:                         w_state_nxt = BTN_IDLE;
    endcase
  end

  always_comb begin
    o_level     = (r_state == BTN_HELD) || (r_state == BTN_DISARM);
    w_press_nxt = ((r_state == BTN_ARM) && (w_state_nxt == BTN_HELD)) || w_rpt_hit;
  end

`ifdef AUTO_REPEAT_EN
  generate
    if (REPEAT_EN) begin : g_repeat
      localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(REPEAT_DELAY - 1);
      localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(REPEAT_PERIOD - 1);
      logic [c_cnt_w-1:0] r_rpt_cnt;
      logic               r_rpt_started;

      assign w_rpt_hit = (r_state == BTN_HELD) && w_sync_p &&
                         (r_rpt_cnt == (r_rpt_started ? c_period_last : c_delay_last));

      // Untouched in DISARM so a release bounce does not restart the repeat timing
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rpt_cnt     <= '0;
          r_rpt_started <= 1'b0;
        end else if (r_state == BTN_ARM && w_state_nxt == BTN_HELD) begin
          r_rpt_cnt     <= '0;
          r_rpt_started <= 1'b0;
        end else if (r_state == BTN_HELD && w_sync_p) begin
          if (w_rpt_hit) begin
            r_rpt_cnt     <= '0;
            r_rpt_started <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end
      end
    end else begin : g_no_repeat
      assign w_rpt_hit = 1'b0;
    end
  endgenerate
`else
  assign w_rpt_hit = 1'b0;
`endif

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner : debounced press pulses and levels for all buttons.
// Optional auto-repeat when AUTO_REPEAT_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_conditioner
  import tic_tac_pkg::*;
#(
  parameter int               N_BTN         = 4,
  parameter int               DB_CYCLES     = 500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(4'b0010),
  parameter int               REPEAT_DELAY  = 25000000,
  parameter int               REPEAT_PERIOD = 10000000
) (
  input logic                  clk,
  input logic                  rst_n,
  button_conditioner_if.slave  bus
);

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(
        .DB_CYCLES     (DB_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_EN     (REPEAT_MASK[i]),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (bus.btn_n[i]),
        .o_press (bus.press[i]),
        .o_level (bus.level[i])
      );
    end
  endgenerate

`ifndef AUTO_REPEAT_EN
  // Repeat configuration has no effect in this build
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

endmodule

`default_nettype wire
